// File: rtl/dwrr_pkg.sv
// Shared definitions for the DWRR arbiter and its request queues.
// Holds common parameter defaults, the source-index type and the lowest-grant helper.
package dwrr_pkg;

    localparam int NUM_REQS_DEF = 4;
    localparam int QWID_DEF     = 8;
    localparam int DWID_DEF     = 8;
    localparam int PSIZE_DEF    = 8;
    localparam int IDWID_DEF    = $clog2(NUM_REQS_DEF);

    // Widest request vector onehot_lowest() accepts; callers zero-extend into it.
    localparam int OH_MAX = 32;

    typedef logic [IDWID_DEF-1:0] dwrr_id_t;

    // Isolates the lowest set bit: v & -v.
    function automatic logic [OH_MAX-1:0] onehot_lowest(input logic [OH_MAX-1:0] v);
        return v & (~v + OH_MAX'(1));
    endfunction

endpackage

// File: rtl/dwrr_fifo.sv
// Single-clock packet FIFO used once per requestor in dwrr_req_queues.
// Push is ignored when full, pop is ignored when empty; read data is the current head.
module dwrr_fifo
    import dwrr_pkg::*;
#(
    parameter int DWID  = DWID_DEF,
    parameter int DEPTH = 4,
    localparam int PTRWID = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DWID-1:0]   wdata,
    output logic [DWID-1:0]   rdata,
    output logic              full,
    output logic              empty,
    output logic [PTRWID:0]   occ
);

    logic [DWID-1:0]   mem [DEPTH];
    logic [PTRWID-1:0] wr_ptr;
    logic [PTRWID-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (occ == (PTRWID+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTRWID'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTRWID'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (PTRWID+1)'(1);
                2'b01:   occ <= occ - (PTRWID+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/dwrr_req_queues.sv
// Per-requestor input queues feeding the DWRR arbiter; pops the granted head into a registered output.
// Optional per-queue saturating drop counters are built when DWRRQ_DROP_CNT_EN is defined.
module dwrr_req_queues
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = NUM_REQS_DEF,
    parameter int DWID     = DWID_DEF,
    parameter int DEPTH    = 4,
    localparam int PTRWID  = $clog2(DEPTH),
    localparam int IDWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQS-1:0]      in_valid,
    input  logic [NUM_REQS*DWID-1:0] in_data,
    output logic [NUM_REQS-1:0]      in_ready,
    output logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS-1:0]      gnt,
    output logic                     out_valid,
    output logic [DWID-1:0]          out_data,
    output logic [IDWID-1:0]         out_id,
    output logic                     err
`ifdef DWRRQ_DROP_CNT_EN
    ,
    output logic [NUM_REQS*8-1:0]    drop_cnt
`endif
);

    logic [NUM_REQS-1:0] q_full;
    logic [NUM_REQS-1:0] q_empty;
    logic [NUM_REQS-1:0] gnt_lo;
    logic [NUM_REQS-1:0] pop;
    logic [DWID-1:0]     q_rdata [NUM_REQS];
    logic [PTRWID:0]     occ_unused [NUM_REQS];
    logic                multi_gnt;
    logic                err_set;
    logic [DWID-1:0]     sel_data;
    logic [IDWID-1:0]    sel_id;

    assign in_ready = ~q_full;
    assign reqs     = ~q_empty;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
        dwrr_fifo #(
            .DWID  (DWID),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[i] & ~q_full[i]),
            .pop   (pop[i]),
            .wdata (in_data[i*DWID +: DWID]),
            .rdata (q_rdata[i]),
            .full  (q_full[i]),
            .empty (q_empty[i]),
            .occ   (occ_unused[i])
        );
    end

    // A multi-bit grant still pops the lowest granted queue, but is flagged.
    assign gnt_lo    = NUM_REQS'(onehot_lowest(OH_MAX'(gnt)));
    assign pop       = gnt_lo & ~q_empty;
    assign multi_gnt = |(gnt & (gnt - NUM_REQS'(1)));
    assign err_set   = multi_gnt | (|(gnt & q_empty));

    // NOTE: defaults before the loop keep this purely combinational (no latch on idle cycles).
    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (pop[i]) begin
                sel_data = q_rdata[i];
                sel_id   = IDWID'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= |pop;
            if (|pop) begin
                out_data <= sel_data;
                out_id   <= sel_id;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DWRRQ_DROP_CNT_EN
    logic [7:0] drop_q [NUM_REQS];

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_drop
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_q[i] <= '0;
            end else if (in_valid[i] && q_full[i] && drop_q[i] != 8'hFF) begin
                drop_q[i] <= drop_q[i] + 8'd1;
            end
        end
        assign drop_cnt[i*8 +: 8] = drop_q[i];
    end
`else
    // Pushes into a full queue are ignored without any record.
`endif

endmodule

// File: tb/tb_dwrr_req_queues.sv
// Self-checking bench for dwrr_req_queues: table-driven vectors plus hand-written corner sequences,
// with a behavioural queue model and an output scoreboard.
module tb_dwrr_req_queues;
    import dwrr_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  reqs;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        err;
`ifdef DWRRQ_DROP_CNT_EN
    logic [31:0] drop_cnt;
`endif

    dwrr_req_queues #(
        .NUM_REQS (4),
        .DWID     (8),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reqs      (reqs),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .err       (err)
`ifdef DWRRQ_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] d;
        logic [3:0]  g;
        logic [3:0]  exp_reqs;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        dwrr_id_t   id;
    } pkt_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mq [4][$];
    pkt_t       sb [$];
    logic       m_err;
    vec_t       vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        sb.delete();
        m_err = 1'b0;
    endtask

    // Drives one cycle of stimulus, advances the model, then checks outputs #1 after the edge.
    task automatic step(input logic [3:0] iv, input logic [31:0] d, input logic [3:0] g);
        logic [3:0] fullp;
        logic [3:0] emptyp;
        logic [3:0] m_reqs;
        logic [3:0] m_rdy;
        logic       exp_ov;
        logic       found;
        pkt_t       p;
        in_valid = iv;
        in_data  = d;
        gnt      = g;
        exp_ov   = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fullp[i]  = (mq[i].size() == 4);
            emptyp[i] = (mq[i].size() == 0);
        end
        if (((g & (g - 4'd1)) != 4'd0) || ((g & emptyp) != 4'd0)) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (g[i] && !found) begin
                found = 1'b1;
                if (!emptyp[i]) begin
                    p.d  = mq[i].pop_front();
                    p.id = dwrr_id_t'(i);
                    sb.push_back(p);
                    exp_ov = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (iv[i] && !fullp[i]) mq[i].push_back(d[i*8 +: 8]);
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got out_data %0h with nothing expected", out_data);
            end else begin
                p = sb.pop_front();
                check("out_data", 64'(out_data), 64'(p.d));
                check("out_id", 64'(out_id), 64'(p.id));
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_reqs[i] = (mq[i].size() != 0);
            m_rdy[i]  = (mq[i].size() != 4);
        end
        check("reqs", 64'(reqs), 64'(m_reqs));
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("err", 64'(err), 64'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
        model_clear();

        // Test 1 and 2 vectors: single packet round trip, then fill/overflow/drain of q2.
        vecs.push_back('{4'b0001, 32'h0000_0011, 4'b0000, 4'b0001, 4'b1111, 1'b0, 8'h00});
        vecs.push_back('{4'b0000, 32'h0000_0000, 4'b0001, 4'b0000, 4'b1111, 1'b1, 8'h11});
        vecs.push_back('{4'b0100, 32'h00A0_0000, 4'b0000, 4'b0100, 4'b1111, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h00A1_0000, 4'b0000, 4'b0100, 4'b1111, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h00A2_0000, 4'b0000, 4'b0100, 4'b1111, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h00A3_0000, 4'b0000, 4'b0100, 4'b1011, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h00A4_0000, 4'b0000, 4'b0100, 4'b1011, 1'b0, 8'h00});
        vecs.push_back('{4'b0000, 32'h0000_0000, 4'b0100, 4'b0100, 4'b1111, 1'b1, 8'hA0});
        vecs.push_back('{4'b0000, 32'h0000_0000, 4'b0100, 4'b0100, 4'b1111, 1'b1, 8'hA1});
        vecs.push_back('{4'b0000, 32'h0000_0000, 4'b0100, 4'b0100, 4'b1111, 1'b1, 8'hA2});
        vecs.push_back('{4'b0000, 32'h0000_0000, 4'b0100, 4'b0000, 4'b1111, 1'b1, 8'hA3});

        #12;
        check("rst_reqs", 64'(reqs), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_id", 64'(out_id), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].iv, vecs[k].d, vecs[k].g);
            check($sformatf("vec%0d_reqs", k), 64'(reqs), 64'(vecs[k].exp_reqs));
            check($sformatf("vec%0d_rdy", k), 64'(in_ready), 64'(vecs[k].exp_rdy));
            check($sformatf("vec%0d_ov", k), 64'(out_valid), 64'(vecs[k].exp_ov));
            if (vecs[k].exp_ov) check($sformatf("vec%0d_od", k), 64'(out_data), 64'(vecs[k].exp_od));
        end

        // Test 3: pop a full q1 while offering 0xB4; the slot frees next cycle and 0xB4 lands then.
        for (int k = 0; k < 4; k++) step(4'b0010, 32'(8'hB0 + k) << 8, 4'b0000);
        check("t3_full", 64'(in_ready[1]), 64'h0);
        step(4'b0010, 32'h0000_B400, 4'b0010);
        check("t3_first_out", 64'(out_data), 64'hB0);
        step(4'b0010, 32'h0000_B400, 4'b0000);
        check("t3_refilled", 64'(in_ready[1]), 64'h0);
        for (int k = 0; k < 4; k++) step(4'b0000, 32'h0, 4'b0010);
        check("t3_last_out", 64'(out_data), 64'hB4);
        check("t3_drained", 64'(reqs[1]), 64'h0);

        // Test 4: grant to empty queue, then a double grant.
        step(4'b0000, 32'h0, 4'b1000);
        check("t4_err_empty", 64'(err), 64'h1);
        step(4'b0000, 32'h0, 4'b0000);
        check("t4_err_sticky", 64'(err), 64'h1);
        step(4'b0011, 32'h0000_D0C0, 4'b0000);
        step(4'b0000, 32'h0, 4'b0011);
        check("t4_multi_data", 64'(out_data), 64'hC0);
        check("t4_multi_id", 64'(out_id), 64'h0);
        check("t4_multi_reqs", 64'(reqs), 64'b0010);
        step(4'b0000, 32'h0, 4'b0010);

        // Test 5: reset mid-stream with all queues loaded and a packet in flight.
        step(4'b1111, 32'hF0E0_D0C0, 4'b0000);
        step(4'b1111, 32'hF1E1_D1C1, 4'b0000);
        step(4'b0000, 32'h0, 4'b0001);
        gnt = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reqs", 64'(reqs), 64'h0);
        check("t5_out_valid", 64'(out_valid), 64'h0);
        check("t5_in_ready", 64'(in_ready), 64'hF);
        check("t5_err", 64'(err), 64'h0);
        check("t5_out_data", 64'(out_data), 64'h0);
        gnt = 4'b0000;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(4'b0000, 32'h0, 4'b0000);
        step(4'b0001, 32'h0000_005A, 4'b0000);
        step(4'b0000, 32'h0, 4'b0001);
        check("t5_fresh_data", 64'(out_data), 64'h5A);

`ifdef DWRRQ_DROP_CNT_EN
        // Test 6: saturating drop counter on q0.
        for (int k = 0; k < 4; k++) step(4'b0001, 32'(8'h60 + k), 4'b0000);
        for (int k = 0; k < 300; k++) step(4'b0001, 32'h0000_0077, 4'b0000);
        check("t6_drop_sat", 64'(drop_cnt), 64'h0000_00FF);
        step(4'b0000, 32'h0, 4'b0000);
        rst_n = 1'b0;
        #1;
        check("t6_drop_rst", 64'(drop_cnt), 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
